// File: rtl/serial_fifo_ctrl_pkg.sv
// rtl/serial_fifo_ctrl_pkg.sv - register offsets, STATUS/CTRL bit positions, CLEAR masks, TX engine states
package serial_fifo_defs;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_CLEAR  = 2'd3;

   localparam int STAT_TX_NFULL   = 0;
   localparam int STAT_RX_NEMPTY  = 1;
   localparam int STAT_RX_OVF     = 2;
   localparam int STAT_TX_OVF     = 3;
   localparam int STAT_RX_CNT_LSB = 8;
   localparam int STAT_TX_CNT_LSB = 16;

   localparam int CTRL_RX_IE   = 0;
   localparam int CTRL_TX_IE   = 1;
   localparam int CTRL_THR_LSB = 8;

   localparam logic [3:0] CLR_RX_OVF   = 4'h1;
   localparam logic [3:0] CLR_TX_OVF   = 4'h2;
   localparam logic [3:0] CLR_RX_FLUSH = 4'h4;
   localparam logic [3:0] CLR_TX_FLUSH = 4'h8;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_HOLD = 1'b1
   } tx_state_e;

endpackage

// File: rtl/serial_fifo_ctrl_sync_fifo.sv
// rtl/serial_fifo_ctrl_sync_fifo.sv - synchronous FIFO with flush; a push into a full FIFO is kept only if a pop happens in the same cycle
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      head,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty = (count_q == '0);
   // count never exceeds DEPTH, so its MSB alone marks full
   assign full  = count_q[DEPTH_LOG2];
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push & ~do_pop) count_d = count_q + 1'b1;
         else if (do_pop & ~do_push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push & ~flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/serial_fifo_ctrl.sv
// rtl/serial_fifo_ctrl.sv - memory-mapped UART front end with RX/TX FIFOs, sticky overflow flags and COM interrupt
module serial_fifo_ctrl
   import serial_fifo_defs::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   input  logic        readEnable_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] dataSave_i,
   output logic [31:0] dataLoad_o,
   output logic        int_o,
   input  logic        rxdReady_i,
   input  logic [7:0]  rxdData_i,
   input  logic        txdBusy_i,
   output logic        txdStart_o,
   output logic [7:0]  txdData_o
);

   localparam int CW = DEPTH_LOG2 + 1;

   logic          rx_full, rx_empty, tx_full, tx_empty;
   logic [7:0]    rx_head, tx_head;
   logic [CW-1:0] rx_count, tx_count;
   logic          rd_data, wr_data, wr_ctrl, wr_clear;
   logic [3:0]    clr;
   logic          tx_start;
   logic [7:0]    rx_cnt8, tx_cnt8, thr_eff;
   logic          unused_ok;

   tx_state_e  tx_state_q, tx_state_d;
   logic       rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
   logic [7:0] thr_q, thr_d;
   logic       rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;

   assign unused_ok = ^dataSave_i[31:16];

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rxdReady_i), .pop(rd_data),
      .flush(|(clr & CLR_RX_FLUSH)), .din(rxdData_i),
      .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(wr_data), .pop(tx_start),
      .flush(|(clr & CLR_TX_FLUSH)), .din(dataSave_i[7:0]),
      .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
   );

   always_comb begin
      rd_data  = enable_i &  readEnable_i & (addr_i == ADDR_DATA);
      wr_data  = enable_i & ~readEnable_i & (addr_i == ADDR_DATA);
      wr_ctrl  = enable_i & ~readEnable_i & (addr_i == ADDR_CTRL);
      wr_clear = enable_i & ~readEnable_i & (addr_i == ADDR_CLEAR);
      clr      = wr_clear ? dataSave_i[3:0] : 4'h0;

      tx_start   = 1'b0;
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (~tx_empty & ~txdBusy_i) begin
               tx_start   = 1'b1;
               tx_state_d = TX_HOLD;
            end
         end
         // busy from the transmitter lags its start by a cycle, so it is not trusted here
         TX_HOLD: tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase

      rx_ovf_d = rx_ovf_q;
      tx_ovf_d = tx_ovf_q;
      if (|(clr & CLR_RX_OVF)) rx_ovf_d = 1'b0;
      if (|(clr & CLR_TX_OVF)) tx_ovf_d = 1'b0;
      if (rxdReady_i & rx_full & ~rd_data) rx_ovf_d = 1'b1;
      if (wr_data & tx_full & ~tx_start)   tx_ovf_d = 1'b1;

      rx_ie_d = rx_ie_q;
      tx_ie_d = tx_ie_q;
      thr_d   = thr_q;
      if (wr_ctrl) begin
         rx_ie_d = dataSave_i[CTRL_RX_IE];
         tx_ie_d = dataSave_i[CTRL_TX_IE];
         thr_d   = dataSave_i[CTRL_THR_LSB +: 8];
      end

      rx_cnt8 = 8'(rx_count);
      tx_cnt8 = 8'(tx_count);
      thr_eff = (thr_q == 8'd0) ? 8'd1 : thr_q;
      int_o   = (rx_ie_q & (rx_cnt8 >= thr_eff)) |
                (tx_ie_q & tx_empty & (tx_state_q == TX_IDLE));

      txdStart_o = tx_start;
      txdData_o  = tx_start ? tx_head : 8'h00;

      dataLoad_o = 32'h0;
      case (addr_i)
         ADDR_DATA: if (~rx_empty) dataLoad_o[7:0] = rx_head;
         ADDR_STATUS: begin
            dataLoad_o[STAT_TX_NFULL]            = ~tx_full;
            dataLoad_o[STAT_RX_NEMPTY]           = ~rx_empty;
            dataLoad_o[STAT_RX_OVF]              = rx_ovf_q;
            dataLoad_o[STAT_TX_OVF]              = tx_ovf_q;
            dataLoad_o[STAT_RX_CNT_LSB +: 8]     = rx_cnt8;
            dataLoad_o[STAT_TX_CNT_LSB +: 8]     = tx_cnt8;
         end
         ADDR_CTRL: begin
            dataLoad_o[CTRL_RX_IE]           = rx_ie_q;
            dataLoad_o[CTRL_TX_IE]           = tx_ie_q;
            dataLoad_o[CTRL_THR_LSB +: 8]    = thr_q;
         end
         default: dataLoad_o = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         rx_ie_q    <= 1'b0;
         tx_ie_q    <= 1'b0;
         thr_q      <= 8'h00;
         rx_ovf_q   <= 1'b0;
         tx_ovf_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         rx_ie_q    <= rx_ie_d;
         tx_ie_q    <= tx_ie_d;
         thr_q      <= thr_d;
         rx_ovf_q   <= rx_ovf_d;
         tx_ovf_q   <= tx_ovf_d;
      end
   end

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// tb/tb_serial_fifo_ctrl.sv - self-checking bench for serial_fifo_ctrl against a queue-based model
module tb_serial_fifo_ctrl;

   localparam int DEPTH    = 16;
   localparam int BUSY_LEN = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_i = 1'b0, readEnable_i = 1'b0;
   logic [1:0]  addr_i = 2'd0;
   logic [31:0] dataSave_i = 32'h0;
   logic [31:0] dataLoad_o;
   logic        int_o;
   logic        rxdReady_i = 1'b0;
   logic [7:0]  rxdData_i = 8'h0;
   logic        txdBusy_i;
   logic        txdStart_o;
   logic [7:0]  txdData_o;

   int checks = 0;
   int errors = 0;

   always #20 clk = ~clk;

   serial_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
      .addr_i(addr_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o), .int_o(int_o),
      .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i), .txdBusy_i(txdBusy_i),
      .txdStart_o(txdStart_o), .txdData_o(txdData_o)
   );

   // transmitter: raises busy one cycle after it sees start, then stays busy BUSY_LEN cycles
   logic busy_force = 1'b0;
   logic start_seen = 1'b0;
   int   busy_cnt = 0;
   always @(posedge clk) begin
      start_seen <= txdStart_o;
      if (start_seen) busy_cnt <= BUSY_LEN;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign txdBusy_i = busy_force | (busy_cnt > 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   logic [7:0] m_rx[$];
   logic [7:0] m_tx[$];
   logic [7:0] start_log[$];
   bit m_rxovf = 0, m_txovf = 0, m_rxie = 0, m_txie = 0, m_hold = 0;
   int m_thr = 0;

   function automatic logic [31:0] m_status();
      logic [7:0] rc, tc;
      rc = 8'(m_rx.size());
      tc = 8'(m_tx.size());
      return {8'h0, tc, rc, 4'h0, m_txovf, m_rxovf, m_rx.size() != 0, m_tx.size() != DEPTH};
   endfunction

   always @(negedge clk) begin
      logic [31:0] e_load;
      logic [7:0]  e_data;
      bit e_start, e_int, rd, wr, rx_popped;
      int thr_e, rxn, txn;
      if (rst) begin
         m_rx.delete(); m_tx.delete();
         m_rxovf = 0; m_txovf = 0; m_rxie = 0; m_txie = 0; m_hold = 0; m_thr = 0;
      end else begin
         e_start = !m_hold && m_tx.size() > 0 && !txdBusy_i;
         e_data  = e_start ? m_tx[0] : 8'h00;
         thr_e   = (m_thr == 0) ? 1 : m_thr;
         e_int   = (m_rxie && m_rx.size() >= thr_e) || (m_txie && m_tx.size() == 0 && !m_hold);
         case (addr_i)
            2'd0:    e_load = (m_rx.size() > 0) ? {24'h0, m_rx[0]} : 32'h0;
            2'd1:    e_load = m_status();
            2'd2:    e_load = {16'h0, 8'(m_thr), 6'h0, m_txie, m_rxie};
            default: e_load = 32'h0;
         endcase
         check("txdStart_o", {31'h0, txdStart_o}, {31'h0, e_start});
         check("txdData_o", {24'h0, txdData_o}, {24'h0, e_data});
         check("int_o", {31'h0, int_o}, {31'h0, e_int});
         check("dataLoad_o", dataLoad_o, e_load);
         if (txdStart_o) start_log.push_back(txdData_o);

         rd = enable_i && readEnable_i && addr_i == 2'd0;
         wr = enable_i && !readEnable_i;
         rxn = m_rx.size();
         txn = m_tx.size();
         rx_popped = rd && rxn > 0;
         if (rx_popped) void'(m_rx.pop_front());
         if (e_start) void'(m_tx.pop_front());
         if (rxdReady_i) begin
            if (rxn < DEPTH || rx_popped) m_rx.push_back(rxdData_i);
            else m_rxovf = 1;
         end
         if (wr && addr_i == 2'd0) begin
            if (txn < DEPTH || e_start) m_tx.push_back(dataSave_i[7:0]);
            else m_txovf = 1;
         end
         if (wr && addr_i == 2'd2) begin
            m_rxie = dataSave_i[0];
            m_txie = dataSave_i[1];
            m_thr  = int'(dataSave_i[15:8]);
         end
         if (wr && addr_i == 2'd3) begin
            if (dataSave_i[0]) m_rxovf = 0;
            if (dataSave_i[1]) m_txovf = 0;
            if (dataSave_i[2]) m_rx.delete();
            if (dataSave_i[3]) m_tx.delete();
         end
         m_hold = e_start;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic acc(input bit r, input logic [1:0] a, input logic [31:0] d, output logic [31:0] q);
      enable_i = 1'b1; readEnable_i = r; addr_i = a; dataSave_i = d;
      #2 q = dataLoad_o;
      tick();
      enable_i = 1'b0; readEnable_i = 1'b0; rxdReady_i = 1'b0;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] q;
      acc(1'b0, a, d, q);
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [31:0] q);
      acc(1'b1, a, 32'h0, q);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rxdReady_i = 1'b1; rxdData_i = b;
      tick();
      rxdReady_i = 1'b0;
   endtask

   initial begin
      logic [31:0] q;
      int n0;
      tick(3);
      rst = 1'b0;

      rd_reg(2'd1, q);
      check("reset STATUS", q, 32'h1);
      check("reset int_o", {31'h0, int_o}, 32'h0);
      tick(100);
      check("no start after reset", start_log.size(), 0);

      wr_reg(2'd0, 32'h41); wr_reg(2'd0, 32'h42); wr_reg(2'd0, 32'h43);
      for (int i = 0; i < 300 && start_log.size() < 3; i++) tick();
      check("three tx starts", start_log.size(), 3);
      if (start_log.size() >= 3) begin
         check("tx byte 0", {24'h0, start_log[0]}, 32'h41);
         check("tx byte 1", {24'h0, start_log[1]}, 32'h42);
         check("tx byte 2", {24'h0, start_log[2]}, 32'h43);
      end
      rd_reg(2'd1, q);
      check("tx count after send", {24'h0, q[23:16]}, 32'h0);
      tick(30);

      for (int i = 0; i <= 16; i++) rx_byte(8'(i));
      rd_reg(2'd1, q);
      check("STATUS rx overflow", q, 32'h00001007);
      for (int i = 0; i < 16; i++) begin
         rd_reg(2'd0, q);
         check("rx read order", q, 32'(i));
      end
      rd_reg(2'd0, q);
      check("empty rx read", q, 32'h0);
      wr_reg(2'd3, 32'h1);
      rd_reg(2'd1, q);
      check("overflow cleared", q, 32'h1);

      wr_reg(2'd2, 32'h0301);
      rd_reg(2'd2, q);
      check("CTRL readback", q, 32'h0301);
      rx_byte(8'h10); rx_byte(8'h11);
      check("int below threshold", {31'h0, int_o}, 32'h0);
      rx_byte(8'h12);
      check("int at threshold", {31'h0, int_o}, 32'h1);
      rd_reg(2'd0, q);
      check("int after pop", {31'h0, int_o}, 32'h0);
      rd_reg(2'd0, q); rd_reg(2'd0, q);
      wr_reg(2'd2, 32'h0);

      for (int i = 0; i < 16; i++) rx_byte(8'(8'h80 + i));
      rxdReady_i = 1'b1; rxdData_i = 8'hAA;
      rd_reg(2'd0, q);
      check("pop with push on full", q, 32'h80);
      rd_reg(2'd1, q);
      check("full push+pop STATUS", q, 32'h00001003);
      for (int i = 1; i < 16; i++) begin
         rd_reg(2'd0, q);
         check("rx drain", q, 32'(8'h80 + i));
      end
      rd_reg(2'd0, q);
      check("rx last byte", q, 32'hAA);

      busy_force = 1'b1;
      tick(2);
      for (int i = 0; i < 5; i++) wr_reg(2'd0, 32'(8'h60 + i));
      rd_reg(2'd1, q);
      check("tx count held", {24'h0, q[23:16]}, 32'h5);
      wr_reg(2'd2, 32'h2);
      check("tx-empty int before flush", {31'h0, int_o}, 32'h0);
      n0 = start_log.size();
      wr_reg(2'd3, 32'h8);
      check("tx-empty int after flush", {31'h0, int_o}, 32'h1);
      busy_force = 1'b0;
      tick(60);
      check("no start after flush", start_log.size(), n0);
      rd_reg(2'd1, q);
      check("STATUS after flush", q, 32'h1);
      wr_reg(2'd2, 32'h0);

      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 49) == 0) busy_force = ~busy_force;
         enable_i     = ($urandom_range(0, 2) == 0);
         readEnable_i = $urandom_range(0, 1) == 1;
         addr_i       = 2'($urandom_range(0, 3));
         dataSave_i   = $urandom;
         dataSave_i[15:8] = 8'($urandom_range(0, 18));
         rxdReady_i   = ($urandom_range(0, 2) == 0) &&
                        !(enable_i && !readEnable_i && addr_i == 2'd3);
         rxdData_i    = 8'($urandom);
         tick();
      end
      rst = 1'b0; enable_i = 1'b0; rxdReady_i = 1'b0; busy_force = 1'b0;
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
